button_events: RTL and testbench

Downstream consumer of the custom controller's `buttons[7:0]` vector. It synchronises the vector into the system clock domain and detects per-button press/release edges. Each edge is encoded as a 4-bit event and queued in a small FIFO. Game logic drains the FIFO through a valid/ready handshake instead of polling a level vector that only changes at the controller's ~60 Hz poll rate.

---
 rtl/button_events.sv | 138 +++++++++++++
 tb/tb_button_events.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/button_events.sv
// rtl/button_events.sv - button edge detector with event FIFO; BUTTON_EVENTS_RELEASE_EN also queues releases
module button_events #(
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     n_rst,
    input  logic [7:0]               buttons,
    input  logic                     evt_ready,
    input  logic                     clear_ovf,
    output logic                     evt_valid,
    output logic [3:0]               evt_data,
    output logic [$clog2(DEPTH):0]   evt_count,
    output logic                     overflow
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

    typedef enum logic {
        IDLE,
        SCAN
    } state_t;

    state_t      state, state_nx;
    logic [7:0]  s1, s2;
    logic [7:0]  prev, prev_nx;
    logic [7:0]  pend, pend_nx;
    logic [7:0]  lvl, lvl_nx;
    logic [7:0]  mask;
    logic [7:0]  diff;
    logic [2:0]  idx;
    logic        push;
    logic [3:0]  push_data;

    logic [AW:0] wr_ptr, rd_ptr;
    logic [3:0]  mem [DEPTH];
    logic        full, empty, pop, wr_en, drop;

`ifdef BUTTON_EVENTS_RELEASE_EN
    assign mask = 8'hFF;
`else
    // Only bits that are now held (low) count, so releases just update prev
    assign mask = ~s2;
`endif

    assign diff = mask & (s2 ^ prev);

    // Two-flop synchroniser for the asynchronous button vector
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            s1 <= 8'hFF;
            s2 <= 8'hFF;
        end else begin
            s1 <= buttons;
            s2 <= s1;
        end
    end

    // Scanner state and snapshot registers
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state <= IDLE;
            prev  <= 8'hFF;
            pend  <= 8'h00;
            lvl   <= 8'hFF;
        end else begin
            state <= state_nx;
            prev  <= prev_nx;
            pend  <= pend_nx;
            lvl   <= lvl_nx;
        end
    end

    // Snapshot changes in IDLE, then emit one event per cycle lowest index first
    always_comb begin
        state_nx  = state;
        prev_nx   = prev;
        pend_nx   = pend;
        lvl_nx    = lvl;
        push      = 1'b0;
        push_data = 4'h0;
        idx       = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (pend[i]) idx = 3'(i);
        end
        case (state)
            IDLE: begin
                if (s2 != prev) begin
                    prev_nx = s2;
                    if (diff != 8'h00) begin
                        pend_nx  = diff;
                        lvl_nx   = s2;
                        state_nx = SCAN;
                    end
                end
            end
            SCAN: begin
                push      = 1'b1;
                push_data = {~lvl[idx], idx};
                pend_nx   = pend & ~(8'd1 << idx);
                if (pend_nx == 8'h00) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    assign empty     = (wr_ptr == rd_ptr);
    assign full      = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign evt_valid = ~empty;
    assign pop       = evt_valid && evt_ready;
    // A pop in the same cycle frees the slot, so a push into a full FIFO still lands
    assign wr_en     = push && (!full || pop);
    assign drop      = push && full && !pop;
    assign evt_data  = mem[rd_ptr[AW-1:0]];
    assign evt_count = wr_ptr - rd_ptr;

    // FIFO pointers and sticky overflow flag (set beats clear)
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            overflow <= 1'b0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + PTR_ONE;
            if (pop)   rd_ptr <= rd_ptr + PTR_ONE;
            if (drop)
                overflow <= 1'b1;
            else if (clear_ovf)
                overflow <= 1'b0;
        end
    end

    // FIFO storage; contents are irrelevant while the pointers say empty
    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr[AW-1:0]] <= push_data;
    end

endmodule

// File: tb/tb_button_events.sv
// tb/tb_button_events.sv - scoreboard bench for button_events
module tb_button_events;

    logic       clk = 1'b0;
    logic       n_rst;
    logic [7:0] buttons;
    logic       evt_ready;
    logic       clear_ovf;
    logic       evt_valid;
    logic [3:0] evt_data;
    logic [3:0] evt_count;
    logic       overflow;

    int checks = 0;
    int errors = 0;
    int mon_checks = 0;
    int mon_errors = 0;
    logic [3:0] exp_q [$];

    button_events #(.DEPTH(8)) dut (
        .clk       (clk),
        .n_rst     (n_rst),
        .buttons   (buttons),
        .evt_ready (evt_ready),
        .clear_ovf (clear_ovf),
        .evt_valid (evt_valid),
        .evt_data  (evt_data),
        .evt_count (evt_count),
        .overflow  (overflow)
    );

    always #5 clk = ~clk;

    // Monitor: every accepted event must match the scoreboard head
    always @(negedge clk) begin
        if (n_rst && evt_valid && evt_ready) begin
            mon_checks++;
            if (exp_q.size() == 0) begin
                mon_errors++;
                $display("FAIL unexpected_event: got %h, none expected", evt_data);
            end else begin
                logic [3:0] e;
                e = exp_q.pop_front();
                if (evt_data !== e) begin
                    mon_errors++;
                    $display("FAIL event_order: got %h expected %h", evt_data, e);
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) step();
    endtask

    task automatic expect_range(input logic [3:0] lo, input logic [3:0] hi);
        for (logic [4:0] v = {1'b0, lo}; v <= {1'b0, hi}; v++) exp_q.push_back(v[3:0]);
    endtask

    initial begin
        n_rst     = 1'b0;
        buttons   = 8'hFF;
        evt_ready = 1'b0;
        clear_ovf = 1'b0;
        wait_cycles(2);
        check("reset_valid", evt_valid, 0);
        check("reset_count", evt_count, 0);
        check("reset_overflow", overflow, 0);
        n_rst = 1'b1;
        wait_cycles(2);

        // Single press: bit 2
        buttons = 8'hFB;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("press_latency_early", evt_valid, 0);
        @(negedge clk);
        check("press_valid", evt_valid, 1);
        check("press_data", evt_data, 4'hA);
        check("press_count", evt_count, 1);
        step();
        exp_q.push_back(4'hA);
        evt_ready = 1'b1;
        wait_cycles(3);

        // Release bit 2, then multi-press 0,2,5,7 on consecutive cycles
        buttons = 8'hFF;
`ifdef BUTTON_EVENTS_RELEASE_EN
        exp_q.push_back(4'h2);
`endif
        wait_cycles(8);
        expect_range(4'h8, 4'h8);
        expect_range(4'hA, 4'hA);
        expect_range(4'hD, 4'hD);
        expect_range(4'hF, 4'hF);
        buttons = 8'h5A;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("multi_before", evt_valid, 0);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check("multi_stream_valid", evt_valid, 1);
        end
        @(negedge clk);
        check("multi_after", evt_valid, 0);
        step();

        // Press remaining bits, then release everything
        exp_q.push_back(4'h9);
        exp_q.push_back(4'hB);
        exp_q.push_back(4'hC);
        exp_q.push_back(4'hE);
        buttons = 8'h00;
        wait_cycles(12);
        evt_ready = 1'b0;
        buttons   = 8'hFF;
        wait_cycles(14);
`ifdef BUTTON_EVENTS_RELEASE_EN
        check("release_count", evt_count, 8);
        expect_range(4'h0, 4'h7);
        evt_ready = 1'b1;
        wait_cycles(12);
        evt_ready = 1'b0;
`else
        check("release_count", evt_count, 0);
        check("release_valid", evt_valid, 0);
`endif

        // Overflow: FF->00->FF->00 with no consumer
        buttons = 8'h00;
        wait_cycles(14);
        buttons = 8'hFF;
        wait_cycles(14);
        buttons = 8'h00;
        wait_cycles(14);
        check("ovf_count", evt_count, 8);
        check("ovf_flag", overflow, 1);
        check("ovf_head", evt_data, 4'h8);
        clear_ovf = 1'b1;
        step();
        clear_ovf = 1'b0;
        @(negedge clk);
        check("ovf_cleared", overflow, 0);
        check("ovf_count_kept", evt_count, 8);
        step();
        expect_range(4'h8, 4'hF);
        evt_ready = 1'b1;
        wait_cycles(12);
        buttons = 8'hFF;
`ifdef BUTTON_EVENTS_RELEASE_EN
        expect_range(4'h0, 4'h7);
`endif
        wait_cycles(14);
        evt_ready = 1'b0;
        step();

        // Fill FIFO to exactly full, then a push coincides with a pop
`ifdef BUTTON_EVENTS_RELEASE_EN
        buttons = 8'h00;
        expect_range(4'h8, 4'hF);
        wait_cycles(14);
`else
        buttons = 8'h80;
        expect_range(4'h8, 4'hE);
        wait_cycles(14);
        buttons = 8'hFF;
        wait_cycles(8);
        buttons = 8'h7F;
        exp_q.push_back(4'hF);
        wait_cycles(8);
`endif
        check("full_count", evt_count, 8);
        check("full_no_ovf", overflow, 0);
`ifdef BUTTON_EVENTS_RELEASE_EN
        buttons = 8'h01;
        exp_q.push_back(4'h0);
`else
        buttons = 8'h7E;
        exp_q.push_back(4'h8);
`endif
        repeat (3) @(posedge clk);
        #1;
        evt_ready = 1'b1;
        @(negedge clk);
        check("pushpop_count", evt_count, 8);
        check("pushpop_no_ovf", overflow, 0);
        step();
        wait_cycles(12);
        check("pushpop_drained", evt_count, 0);

        // Back to idle, then reset in the middle of a scan
        buttons = 8'hFF;
`ifdef BUTTON_EVENTS_RELEASE_EN
        expect_range(4'h1, 4'h7);
`endif
        wait_cycles(14);
        evt_ready = 1'b0;
        buttons   = 8'h00;
        repeat (4) @(posedge clk);
        #1;
        check("prereset_valid", evt_valid, 1);
        n_rst = 1'b0;
        #1;
        check("async_valid", evt_valid, 0);
        check("async_count", evt_count, 0);
        check("async_overflow", overflow, 0);
        wait_cycles(2);
        n_rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("post_reset_early", evt_valid, 0);
        @(negedge clk);
        check("post_reset_valid", evt_valid, 1);
        check("post_reset_data", evt_data, 4'h8);
        step();
        expect_range(4'h8, 4'hF);
        evt_ready = 1'b1;

        // Bounded drain of remaining expectations
        for (int t = 0; t < 100 && exp_q.size() != 0; t++) step();
        check("scoreboard_empty", exp_q.size(), 0);
        wait_cycles(4);
        check("final_count", evt_count, 0);

        checks = checks + mon_checks;
        errors = errors + mon_errors;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
